// File: rtl/match_event_reporter_if.sv
// Bundle of configuration, match-filter input and event-FIFO output signals
// shared between the match event reporter and whoever drives/drains it.
interface match_event_reporter_if #(
    parameter int FIFO_AW = 3
);
    logic               cfg_write;
    logic               cfg_addr;
    logic [31:0]        cfg_data;
    logic               mf_valid;
    logic               mf_match;
    logic [31:0]        timestamp;
    logic               rd_en;
    logic [31:0]        ev_data;
    logic               ev_empty;
    logic [FIFO_AW:0]   ev_level;
    logic [15:0]        drop_count;
    logic               busy;

    modport master (
        output cfg_write, cfg_addr, cfg_data, mf_valid, mf_match, timestamp, rd_en,
        input  ev_data, ev_empty, ev_level, drop_count, busy
    );

    modport slave (
        input  cfg_write, cfg_addr, cfg_data, mf_valid, mf_match, timestamp, rd_en,
        output ev_data, ev_empty, ev_level, drop_count, busy
    );
endinterface

// File: rtl/match_event_reporter.sv
// Qualifies match-filter hits (N in a row), applies a sample-count holdoff and
// timestamps each detection into a small first-word-fall-through event FIFO.
module match_event_reporter #(
    parameter int FIFO_AW = 3,
    parameter int HOLD_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    match_event_reporter_if.slave   bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   LVL_FULL = DEPTH[FIFO_AW:0];
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_HOLDOFF} state_t;

    state_t              r_state, w_state_next;
    logic                r_en;
    logic [3:0]          r_min_hits;
    logic [HOLD_W-1:0]   r_holdoff;
    logic [3:0]          r_hit_cnt, w_hit_cnt_next;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_next;
    logic                r_busy;
    logic                w_en_next, w_push;
    logic [3:0]          w_min_eff;
    logic [4:0]          w_hits_inc;
    logic                w_unused_cfg;

    logic [31:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
    logic [FIFO_AW:0]    r_level;
    logic [31:0]         r_ev_data;
    logic [15:0]         r_drop_count;
    logic                w_full, w_pop, w_wr, w_drop;

    assign w_unused_cfg = &{1'b0, bus.cfg_data[30:4]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_min_hits <= 4'd1;
            r_holdoff  <= '0;
        end else if (bus.cfg_write) begin
            if (!bus.cfg_addr) begin
                r_en       <= bus.cfg_data[31];
                r_min_hits <= bus.cfg_data[3:0];
            end else begin
                r_holdoff  <= bus.cfg_data[HOLD_W-1:0];
            end
        end
    end

    // A disabling write must drop the FSM to IDLE on the very next edge, so look ahead at it.
    assign w_en_next  = (bus.cfg_write && !bus.cfg_addr) ? bus.cfg_data[31] : r_en;
    assign w_min_eff  = (r_min_hits == 4'd0) ? 4'd1 : r_min_hits;
    assign w_hits_inc = {1'b0, r_hit_cnt} + 5'd1;

    always_comb begin
        w_state_next    = r_state;
        w_hit_cnt_next  = r_hit_cnt;
        w_hold_cnt_next = r_hold_cnt;
        w_push          = 1'b0;
        if (!w_en_next) begin
            w_state_next    = S_IDLE;
            w_hit_cnt_next  = 4'd0;
            w_hold_cnt_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next   = S_SEARCH;
                    w_hit_cnt_next = 4'd0;
                end
                S_SEARCH: begin
                    if (bus.mf_valid) begin
                        if (!bus.mf_match) begin
                            w_hit_cnt_next = 4'd0;
                        end else if (w_hits_inc >= {1'b0, w_min_eff}) begin
                            w_push          = 1'b1;
                            w_hit_cnt_next  = 4'd0;
                            w_hold_cnt_next = r_holdoff;
                            w_state_next    = (r_holdoff == '0) ? S_SEARCH : S_HOLDOFF;
                        end else begin
                            w_hit_cnt_next  = (r_hit_cnt == 4'hF) ? 4'hF : w_hits_inc[3:0];
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (bus.mf_valid) begin
                        w_hold_cnt_next = r_hold_cnt - HOLD_ONE;
                        if (r_hold_cnt <= HOLD_ONE) begin
                            w_state_next    = S_SEARCH;
                            w_hit_cnt_next  = 4'd0;
                            w_hold_cnt_next = '0;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hit_cnt  <= 4'd0;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hit_cnt  <= w_hit_cnt_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_busy     <= (w_state_next == S_HOLDOFF);
        end
    end

    // A pop frees the slot a full-FIFO push needs, so push+pop when full both succeed.
    assign w_full       = (r_level == LVL_FULL);
    assign w_pop        = bus.rd_en && (r_level != '0);
    assign w_wr         = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_ONE;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.timestamp;
        end
    end

    // Head register: bypass the incoming timestamp whenever it becomes the new head.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ev_data <= 32'd0;
        end else if (r_level == '0) begin
            if (w_wr) begin
                r_ev_data <= bus.timestamp;
            end
        end else if (w_pop) begin
            if (r_level == LVL_ONE) begin
                if (w_wr) begin
                    r_ev_data <= bus.timestamp;
                end
            end else begin
                r_ev_data <= r_mem[w_rd_ptr_inc];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_count <= 16'd0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_pop && !w_wr) begin
                r_level <= r_level - LVL_ONE;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign bus.ev_data    = r_ev_data;
    assign bus.ev_empty   = (r_level == '0);
    assign bus.ev_level   = r_level;
    assign bus.drop_count = r_drop_count;
    assign bus.busy       = r_busy;
endmodule
